// File: rtl/ldmx_daq_event_pager_pkg.sv
// Shared types and header layout for the LDMX DAQ event pager.
// FSM encoding, header field positions and page-mode clamp.
package ldmx_daq_event_pager_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HDR  = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam int TRUNC_BIT = 23;
    localparam int CH_LSB    = 16;
    localparam int CH_W      = 4;
    localparam int LEN_W     = 16;

    function automatic logic [1:0] mode_clamp(
        input logic [1:0] m,
        input int         num_modes
    );
        if (int'(m) > num_modes - 1)
            return 2'(num_modes - 1);
        return m;
    endfunction

endpackage

// File: rtl/ldmx_daq_event_pager_ram.sv
// Simple dual-port page RAM: one write port, registered read port.
// Only the read register is reset so the array still maps to block RAM.
module ldmx_daq_event_pager_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (clr)
            rdata <= '0;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/ldmx_daq_event_pager.sv
// Multi-channel event pager: round-robin grant, one event per ring page,
// header written after payload, oldest committed page exposed for readout.
module ldmx_daq_event_pager
    import ldmx_daq_event_pager_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int NUM_CH        = 4,
    parameter int LOG2_MEM      = 15,
    parameter int LOG2_MIN_PAGE = 9,
    parameter int NUM_MODES     = 3
) (
    input  logic                                axi_clk,
    input  logic                                reset_n,
    input  logic [1:0]                          cfg_page_mode,
    input  logic                                cfg_enable,
    input  logic                                clear,
    input  logic [NUM_CH*DATA_W-1:0]            in_data,
    input  logic [NUM_CH-1:0]                   in_valid,
    input  logic [NUM_CH-1:0]                   in_sof,
    input  logic [NUM_CH-1:0]                   in_eof,
    output logic [NUM_CH-1:0]                   in_ready,
    input  logic [LOG2_MIN_PAGE+NUM_MODES-2:0]  rd_addr,
    output logic [DATA_W-1:0]                   rd_data,
    input  logic                                rd_advance,
    output logic [LOG2_MEM-LOG2_MIN_PAGE:0]     nevents,
    output logic                                full,
    output logic                                empty,
    output logic [15:0]                         drop_count
);

    localparam int AW = LOG2_MIN_PAGE + NUM_MODES - 1;
    localparam int PW = LOG2_MEM - LOG2_MIN_PAGE;
    localparam int NW = PW + 1;

    state_t state, state_nxt;

    logic              init_done;
    logic [1:0]        mode;
    logic [PW-1:0]     w_page, r_page, pmask;
    logic [NW-1:0]     num_pages;
    logic [AW-1:0]     page_mask, wptr, rd_addr_q, wr_off;
    logic [CH_W-1:0]   rr, grant, pick;
    logic              found, trunc, silent, adv_q, advance;
    logic              g_valid, g_eof;
    logic [DATA_W-1:0] g_data, hdr, wr_data;
    logic              xfer, start, store, commit, drop_eof, wr_en;
    logic [LOG2_MEM-1:0] wr_addr, rd_ram_addr;
    int                sh;
    int                cand;

    assign sh        = LOG2_MIN_PAGE + int'(mode);
    assign num_pages = NW'(1) << (PW - int'(mode));
    assign pmask     = {PW{1'b1}} >> mode;
    assign page_mask = {AW{1'b1}} >> (NUM_MODES - 1 - int'(mode));
    assign full      = nevents == num_pages;
    assign empty     = nevents == '0;
    assign advance   = rd_advance & ~adv_q & ~empty;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = int'(rr) + i;
            if (cand >= NUM_CH)
                cand = cand - NUM_CH;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && c == cand && in_valid[c] && in_sof[c]) begin
                    found = 1'b1;
                    pick  = CH_W'(c);
                end
            end
        end
    end

    always_comb begin
        g_valid  = 1'b0;
        g_eof    = 1'b0;
        g_data   = '0;
        in_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant == CH_W'(c)) begin
                g_valid = in_valid[c];
                g_eof   = in_eof[c];
                g_data  = in_data[c*DATA_W +: DATA_W];
            end
            in_ready[c] = (state == FILL || state == DROP) &&
                          grant == CH_W'(c);
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        store     = 1'b0;
        commit    = 1'b0;
        drop_eof  = 1'b0;
        xfer      = g_valid && (state == FILL || state == DROP);
        unique case (state)
            IDLE: begin
                if (cfg_enable && found) begin
                    start     = 1'b1;
                    state_nxt = full ? DROP : FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    store = wptr < page_mask;
                    if (g_eof)
                        state_nxt = HDR;
                end
            end
            HDR: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            DROP: begin
                if (xfer && g_eof) begin
                    drop_eof  = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
        // A flushed event keeps its grant and drains silently to eof
        if (clear) begin
            start    = 1'b0;
            store    = 1'b0;
            commit   = 1'b0;
            drop_eof = 1'b0;
            if (state == FILL)
                state_nxt = (xfer && g_eof) ? IDLE : DROP;
            else if (state != DROP)
                state_nxt = IDLE;
        end
    end

    always_comb begin
        hdr                     = '0;
        hdr[TRUNC_BIT]          = trunc;
        hdr[CH_LSB +: CH_W]     = grant;
        hdr[LEN_W-1:0]          = LEN_W'(wptr);
        wr_en   = store | commit;
        wr_off  = commit ? '0 : wptr + 1'b1;
        wr_data = commit ? hdr : g_data;
        wr_addr = (LOG2_MEM'(w_page) << sh) |
                  LOG2_MEM'(wr_off & page_mask);
        rd_ram_addr = (LOG2_MEM'(r_page) << sh) |
                      LOG2_MEM'(rd_addr_q & page_mask);
    end

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            init_done  <= 1'b0;
            mode       <= '0;
            w_page     <= '0;
            r_page     <= '0;
            nevents    <= '0;
            drop_count <= '0;
            rr         <= '0;
            grant      <= '0;
            wptr       <= '0;
            trunc      <= 1'b0;
            silent     <= 1'b0;
            adv_q      <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state     <= state_nxt;
            adv_q     <= rd_advance;
            rd_addr_q <= rd_addr;
            if (clear || !init_done) begin
                init_done <= 1'b1;
                mode      <= mode_clamp(cfg_page_mode, NUM_MODES);
            end
            if (clear) begin
                w_page     <= '0;
                r_page     <= '0;
                nevents    <= '0;
                drop_count <= '0;
                rr         <= '0;
                wptr       <= '0;
                trunc      <= 1'b0;
                silent     <= 1'b1;
            end else begin
                if (start) begin
                    grant  <= pick;
                    rr     <= pick;
                    wptr   <= '0;
                    trunc  <= 1'b0;
                    silent <= 1'b0;
                end
                if (state == FILL && xfer) begin
                    if (store)
                        wptr <= wptr + 1'b1;
                    else
                        trunc <= 1'b1;
                end
                if (commit)
                    w_page <= (w_page + 1'b1) & pmask;
                if (advance)
                    r_page <= (r_page + 1'b1) & pmask;
                if (commit && !advance)
                    nevents <= nevents + 1'b1;
                else if (!commit && advance)
                    nevents <= nevents - 1'b1;
                if (drop_eof && !silent && drop_count != 16'hFFFF)
                    drop_count <= drop_count + 1'b1;
            end
        end
    end

    ldmx_daq_event_pager_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (LOG2_MEM)
    ) u_ram (
        .clk   (axi_clk),
        .rst_n (reset_n),
        .clr   (clear),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_ram_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_ldmx_daq_event_pager.sv
// Directed bench for the event pager: headers, arbitration, truncation,
// full/drop, wrap, commit+advance overlap, clear with mode change, reset.
module tb_ldmx_daq_event_pager;

    logic         axi_clk = 1'b0;
    logic         reset_n;
    logic [1:0]   cfg_page_mode;
    logic         cfg_enable;
    logic         clear;
    logic [127:0] in_data;
    logic [3:0]   in_valid, in_sof, in_eof, in_ready;
    logic [10:0]  rd_addr;
    logic [31:0]  rd_data;
    logic         rd_advance;
    logic [6:0]   nevents;
    logic         full, empty;
    logic [15:0]  drop_count;

    int nerr = 0;
    int nchk = 0;
    int viol = 0;

    always #5 axi_clk = ~axi_clk;

    ldmx_daq_event_pager dut (
        .axi_clk       (axi_clk),
        .reset_n       (reset_n),
        .cfg_page_mode (cfg_page_mode),
        .cfg_enable    (cfg_enable),
        .clear         (clear),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_eof        (in_eof),
        .in_ready      (in_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_advance    (rd_advance),
        .nevents       (nevents),
        .full          (full),
        .empty         (empty),
        .drop_count    (drop_count)
    );

    always @(negedge axi_clk)
        if ($countones(in_ready) > 1)
            viol++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input int ch, input int n,
                        input logic [31:0] base, input int clr_at);
        for (int i = 0; i < n; i++) begin
            int w;
            in_valid[ch] = 1'b1;
            in_sof[ch]   = (i == 0);
            in_eof[ch]   = (i == n - 1);
            in_data[ch*32 +: 32] = base + 32'(i);
            w = 0;
            while (!in_ready[ch] && w < 4000) begin
                @(negedge axi_clk);
                w++;
            end
            if (!in_ready[ch]) begin
                check("ready_timeout", 32'(ch), 32'hFFFF_FFFF);
                in_valid[ch] = 1'b0;
                in_sof[ch]   = 1'b0;
                in_eof[ch]   = 1'b0;
                return;
            end
            if (i == clr_at)
                clear = 1'b1;
            @(negedge axi_clk);
            clear = 1'b0;
        end
        in_valid[ch] = 1'b0;
        in_sof[ch]   = 1'b0;
        in_eof[ch]   = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        rd_addr = 11'(a);
        @(negedge axi_clk);
        @(negedge axi_clk);
        v = rd_data;
    endtask

    task automatic settle();
        repeat (3) @(negedge axi_clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge axi_clk);
        clear = 1'b0;
        @(negedge axi_clk);
    endtask

    task automatic adv();
        rd_advance = 1'b1;
        @(negedge axi_clk);
        rd_advance = 1'b0;
        @(negedge axi_clk);
    endtask

    initial begin
        logic [31:0] v;
        longint t0;
        reset_n       = 1'b0;
        cfg_page_mode = 2'd0;
        cfg_enable    = 1'b1;
        clear         = 1'b0;
        in_data       = '0;
        in_valid      = '0;
        in_sof        = '0;
        in_eof        = '0;
        rd_addr       = '0;
        rd_advance    = 1'b0;
        repeat (3) @(negedge axi_clk);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_nev", 32'(nevents), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_rdata", rd_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge axi_clk);

        // 1: single 5-word event on ch2
        send(2, 5, 32'hA000, -1);
        settle();
        check("t1_nev", 32'(nevents), 1);
        check("t1_empty", 32'(empty), 0);
        rd(0, v);
        check("t1_hdr", v, 32'h0002_0005);
        rd_addr = 11'd1;
        @(negedge axi_clk);
        check("t1_lat1", rd_data, 32'h0002_0005);
        @(negedge axi_clk);
        check("t1_lat2", rd_data, 32'hA000);
        for (int k = 2; k <= 5; k++) begin
            rd(k, v);
            check("t1_data", v, 32'hA000 + 32'(k - 1));
        end

        // 2: simultaneous requests on ch0 and ch3 from rr=0
        pulse_clear();
        viol = 0;
        fork
            send(0, 3, 32'h300, -1);
            send(3, 4, 32'h400, -1);
        join
        settle();
        check("t2_nev", 32'(nevents), 2);
        rd(0, v);
        check("t2_hdr_first", v, 32'h0003_0004);
        rd(1, v);
        check("t2_dat_first", v, 32'h400);
        adv();
        rd(0, v);
        check("t2_hdr_second", v, 32'h0000_0003);
        rd(1, v);
        check("t2_dat_second", v, 32'h300);
        check("t2_onehot", 32'(viol), 0);

        // 3: 600-word event truncates at 511 stored words
        pulse_clear();
        t0 = longint'($time);
        send(1, 600, 32'h1000, -1);
        check("t3_cycles", 32'((longint'($time) - t0) / 10), 601);
        settle();
        check("t3_nev", 32'(nevents), 1);
        rd(0, v);
        check("t3_hdr", v, 32'h0081_01FF);
        rd(511, v);
        check("t3_last", v, 32'h11FE);

        // 4: fill 64 pages, drop two events, wrap after one advance
        pulse_clear();
        for (int k = 0; k < 64; k++)
            send(0, 1, 32'h5000 + 32'(k), -1);
        settle();
        check("t4_full", 32'(full), 1);
        check("t4_nev64", 32'(nevents), 64);
        send(1, 3, 32'h600, -1);
        send(1, 3, 32'h610, -1);
        settle();
        check("t4_drop", 32'(drop_count), 2);
        check("t4_nev_hold", 32'(nevents), 64);
        adv();
        check("t4_nev63", 32'(nevents), 63);
        check("t4_notfull", 32'(full), 0);
        rd(1, v);
        check("t4_page1", v, 32'h5001);
        send(2, 1, 32'h7777, -1);
        settle();
        check("t4_refull", 32'(nevents), 64);
        for (int k = 0; k < 63; k++)
            adv();
        check("t4_nev1", 32'(nevents), 1);
        rd(0, v);
        check("t4_wrap_hdr", v, 32'h0002_0001);
        rd(1, v);
        check("t4_wrap_dat", v, 32'h7777);

        // 5: commit and advance on the same edge
        pulse_clear();
        send(0, 1, 32'h10, -1);
        send(1, 2, 32'h20, -1);
        send(2, 3, 32'h30, -1);
        settle();
        check("t5_nev3", 32'(nevents), 3);
        in_valid[3] = 1'b1;
        in_sof[3]   = 1'b1;
        in_eof[3]   = 1'b1;
        in_data[96 +: 32] = 32'h50;
        @(negedge axi_clk);
        @(negedge axi_clk);
        in_valid[3] = 1'b0;
        in_sof[3]   = 1'b0;
        in_eof[3]   = 1'b0;
        rd_advance  = 1'b1;
        @(negedge axi_clk);
        rd_advance  = 1'b0;
        check("t5_overlap", 32'(nevents), 3);
        rd(0, v);
        check("t5_rpage1", v, 32'h0001_0002);
        rd_advance = 1'b1;
        repeat (3) @(negedge axi_clk);
        rd_advance = 1'b0;
        @(negedge axi_clk);
        check("t5_level", 32'(nevents), 2);
        adv();
        adv();
        check("t5_empty", 32'(empty), 1);
        adv();
        check("t5_empty_adv", 32'(nevents), 0);
        send(1, 2, 32'h40, -1);
        settle();
        rd(0, v);
        check("t5_rpage_hold", v, 32'h0001_0002);
        rd(1, v);
        check("t5_rpage_dat", v, 32'h40);

        // 6: clear mid-event with switch to mode 2
        cfg_page_mode = 2'd2;
        send(0, 10, 32'h900, 4);
        settle();
        check("t6_nev", 32'(nevents), 0);
        check("t6_drop", 32'(drop_count), 0);
        send(1, 1000, 32'hA000, -1);
        settle();
        rd(0, v);
        check("t6_hdr", v, 32'h0001_03E8);
        rd(1000, v);
        check("t6_last", v, 32'hA3E7);
        for (int k = 0; k < 15; k++)
            send(2, 1, 32'hB000 + 32'(k), -1);
        settle();
        check("t6_nev16", 32'(nevents), 16);
        check("t6_full", 32'(full), 1);
        send(3, 2, 32'hC000, -1);
        settle();
        check("t6_drop16", 32'(drop_count), 1);

        // asynchronous reset in the middle of an event
        in_valid[2] = 1'b1;
        in_sof[2]   = 1'b1;
        in_data[64 +: 32] = 32'hD000;
        repeat (3) @(negedge axi_clk);
        #2 reset_n = 1'b0;
        #1;
        check("ar_ready", 32'(in_ready), 0);
        check("ar_nev", 32'(nevents), 0);
        check("ar_empty", 32'(empty), 1);
        check("ar_full", 32'(full), 0);
        check("ar_drop", 32'(drop_count), 0);
        check("ar_rdata", rd_data, 0);
        in_valid = '0;
        in_sof   = '0;
        @(negedge axi_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge axi_clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
